// File: rtl/mac_pipe.sv
// Three-stage signed multiply-add o = a*b + c with overflow flag; optional SATURATE_EN clamps overflowed results.
// Latency 3 cycles from accepted input to o_valid, one result per cycle; done_cnt counts output handshakes.
// Backpressure: o_valid & ~o_ready freezes every stage; clr flushes in-flight data and zeroes done_cnt.
module mac_pipe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int CNT_W  = 16
) (
    input  logic              clk50MHz,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ACC_W-1:0]  c,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [ACC_W-1:0]  o_data,
    output logic              o_ovf,
    output logic [CNT_W-1:0]  done_cnt
);

    logic                       stall;
    logic                       v1;
    logic                       v2;
    logic signed [DATA_W-1:0]   a1;
    logic signed [DATA_W-1:0]   b1;
    logic signed [ACC_W-1:0]    c1;
    logic signed [ACC_W-1:0]    p2;
    logic signed [ACC_W-1:0]    c2;
    logic signed [2*DATA_W-1:0] ax;
    logic signed [2*DATA_W-1:0] bx;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W:0]      sum;
    logic                       ovf;
    logic [ACC_W-1:0]           res;

    assign stall    = o_valid & ~o_ready;
    assign in_ready = ~stall & ~clr;

    assign ax   = (2*DATA_W)'(a1);
    assign bx   = (2*DATA_W)'(b1);
    assign prod = ax * bx;

    // One guard bit makes overflow visible as a mismatch of the top two sum bits.
    assign sum = (ACC_W+1)'(p2) + (ACC_W+1)'(c2);
    assign ovf = sum[ACC_W] ^ sum[ACC_W-1];

`ifdef SATURATE_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    always_comb begin
        res = sum[ACC_W-1:0];
        if (ovf) begin
            res = sum[ACC_W] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    always_comb begin
        res = sum[ACC_W-1:0];
    end
`endif

    always_ff @(posedge clk50MHz or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            o_valid <= 1'b0;
            a1      <= '0;
            b1      <= '0;
            c1      <= '0;
            p2      <= '0;
            c2      <= '0;
            o_data  <= '0;
            o_ovf   <= 1'b0;
        end else if (clr) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            o_valid <= 1'b0;
        end else if (!stall) begin
            v1      <= in_valid;
            a1      <= a;
            b1      <= b;
            c1      <= c;
            v2      <= v1;
            p2      <= ACC_W'(prod);
            c2      <= c1;
            o_valid <= v2;
            o_data  <= res;
            o_ovf   <= ovf;
        end
    end

    // clr takes priority over a handshake in the same cycle.
    always_ff @(posedge clk50MHz or posedge rst) begin
        if (rst) begin
            done_cnt <= '0;
        end else if (clr) begin
            done_cnt <= '0;
        end else if (o_valid && o_ready) begin
            done_cnt <= done_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mac_pipe.sv
// Bench for mac_pipe: a negedge scoreboard checks every output word; scenario tasks check timing and control.
module tb_mac_pipe;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 20;
    localparam int CNT_W  = 16;
    localparam int WCNT_W = 4;

    logic              clk50MHz = 1'b0;
    logic              rst;
    logic              clr;
    logic              in_valid;
    logic              o_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [ACC_W-1:0]  c;
    logic              in_ready;
    logic              o_valid;
    logic [ACC_W-1:0]  o_data;
    logic              o_ovf;
    logic [CNT_W-1:0]  done_cnt;
    logic              w_in_ready;
    logic              w_o_valid;
    logic [ACC_W-1:0]  w_o_data;
    logic              w_o_ovf;
    logic [WCNT_W-1:0] w_done_cnt;

    int checks   = 0;
    int failures = 0;
    logic [ACC_W:0] sb[$];

    always #10 clk50MHz = ~clk50MHz;

    mac_pipe #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk50MHz(clk50MHz), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
        .o_ovf(o_ovf), .done_cnt(done_cnt)
    );

    // Narrow-counter instance sharing all inputs, used only for the wrap scenario.
    mac_pipe #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(WCNT_W)) dut_w (
        .clk50MHz(clk50MHz), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(w_in_ready),
        .a(a), .b(b), .c(c), .o_valid(w_o_valid), .o_ready(o_ready), .o_data(w_o_data),
        .o_ovf(w_o_ovf), .done_cnt(w_done_cnt)
    );

    function automatic logic [ACC_W:0] model(int ai, int bi, int ci);
        longint s;
        longint mx;
        longint mn;
        logic ov;
        logic [ACC_W-1:0] d;
        s  = longint'(ai) * longint'(bi) + longint'(ci);
        mx = (longint'(1) <<< (ACC_W-1)) - 1;
        mn = -mx - 1;
        ov = (s > mx) || (s < mn);
        d  = ACC_W'(s);
`ifdef SATURATE_EN
        if (s > mx) d = ACC_W'(mx);
        if (s < mn) d = ACC_W'(mn);
`endif
        return {ov, d};
    endfunction

    always @(negedge clk50MHz) begin
        logic [ACC_W:0] exp_w;
        if (rst || clr) begin
            sb.delete();
        end else begin
            if (o_valid && o_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_output got o_data=%h o_ovf=%b, none expected", o_data, o_ovf);
                end else begin
                    exp_w = sb.pop_front();
                    if ({o_ovf, o_data} !== exp_w) begin
                        failures++;
                        $display("FAIL sb_result got ovf=%b data=%h, expected ovf=%b data=%h",
                                 o_ovf, o_data, exp_w[ACC_W], exp_w[ACC_W-1:0]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(int'($signed(a)), int'($signed(b)), int'($signed(c))));
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk50MHz);
            #1;
        end
    endtask

    task automatic drive(int ai, int bi, int ci);
        a        = DATA_W'(ai);
        b        = DATA_W'(bi);
        c        = ACC_W'(ci);
        in_valid = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; o_ready = 1'b1;
        a = '0; b = '0; c = '0;
        tick(2);
        checks++;
        if ({o_valid, o_data, o_ovf, done_cnt, in_ready} !== {1'b0, {ACC_W{1'b0}}, 1'b0, {CNT_W{1'b0}}, 1'b1}) begin
            failures++;
            $display("FAIL reset_state got v=%b d=%h ovf=%b cnt=%0d rdy=%b, expected 0/0/0/0/1",
                     o_valid, o_data, o_ovf, done_cnt, in_ready);
        end
        @(negedge clk50MHz);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_basic;
        drive(3, 4, 5);
        tick(1);
        in_valid = 1'b0;
        tick(1);
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early got o_valid=%b, expected 0", o_valid);
        end
        tick(1);
        checks++;
        if ({o_valid, o_ovf, o_data} !== {1'b1, 1'b0, ACC_W'(17)}) begin
            failures++;
            $display("FAIL basic_latency got v=%b ovf=%b d=%0d, expected 1/0/17", o_valid, o_ovf, o_data);
        end
        tick(1);
        checks++;
        if (done_cnt !== CNT_W'(1)) begin
            failures++;
            $display("FAIL basic_count got %0d, expected 1", done_cnt);
        end
    endtask

    task automatic test_back_to_back;
        drive(-128, -128, 0);
        tick(1);
        drive(127, -128, -1);
        tick(1);
        in_valid = 1'b0;
        tick(1);
        checks++;
        if ({o_valid, o_data} !== {1'b1, ACC_W'(16384)}) begin
            failures++;
            $display("FAIL b2b_first got v=%b d=%h, expected 1/%h", o_valid, o_data, ACC_W'(16384));
        end
        tick(1);
        checks++;
        if ({o_valid, o_data} !== {1'b1, ACC_W'(-16257)}) begin
            failures++;
            $display("FAIL b2b_second got v=%b d=%h, expected 1/%h", o_valid, o_data, ACC_W'(-16257));
        end
        tick(1);
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got o_valid=%b, expected 0", o_valid);
        end
    endtask

    task automatic test_overflow;
        logic [ACC_W-1:0] exp_d;
`ifdef SATURATE_EN
        exp_d = 20'h7FFFF;
`else
        exp_d = 20'h83F00;
`endif
        drive(127, 127, 'h7FFFF);
        tick(1);
        in_valid = 1'b0;
        tick(2);
        checks++;
        if ({o_valid, o_ovf, o_data} !== {1'b1, 1'b1, exp_d}) begin
            failures++;
            $display("FAIL overflow got v=%b ovf=%b d=%h, expected 1/1/%h", o_valid, o_ovf, o_data, exp_d);
        end
        tick(1);
    endtask

    task automatic test_stall;
        o_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive(i, 1, 0);
            tick(1);
        end
        drive(4, 1, 0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({in_ready, o_valid, o_data} !== {1'b0, 1'b1, ACC_W'(1)}) begin
                failures++;
                $display("FAIL stall_hold cycle %0d got rdy=%b v=%b d=%0d, expected 0/1/1", i, in_ready, o_valid, o_data);
            end
            tick(1);
        end
        o_ready = 1'b1;
        tick(1);
        in_valid = 1'b0;
        tick(6);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL stall_drain got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) begin
            drive(10 + i, 3, 1);
            tick(1);
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({o_valid, o_data, done_cnt, in_ready} !== {1'b0, {ACC_W{1'b0}}, {CNT_W{1'b0}}, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid got v=%b d=%h cnt=%0d rdy=%b, expected 0/0/0/1", o_valid, o_data, done_cnt, in_ready);
        end
        tick(1);
        @(negedge clk50MHz);
        rst = 1'b0;
        tick(1);
        drive(2, 2, 2);
        tick(1);
        in_valid = 1'b0;
        tick(2);
        checks++;
        if ({o_valid, o_data} !== {1'b1, ACC_W'(6)}) begin
            failures++;
            $display("FAIL reset_restart got v=%b d=%0d, expected 1/6", o_valid, o_data);
        end
        tick(2);
    endtask

    task automatic test_clr;
        drive(5, 5, 0);
        tick(1);
        drive(6, 6, 0);
        tick(1);
        drive(9, 9, 9);
        clr = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL clr_ready got in_ready=%b, expected 0", in_ready);
        end
        tick(1);
        clr = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (done_cnt !== '0) begin
            failures++;
            $display("FAIL clr_count got %0d, expected 0", done_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (o_valid !== 1'b0) begin
                failures++;
                $display("FAIL clr_flush cycle %0d got o_valid=%b, expected 0", i, o_valid);
            end
            tick(1);
        end
    endtask

    task automatic test_wrap;
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(i, 1, 0);
            tick(1);
        end
        in_valid = 1'b0;
        tick(5);
        checks++;
        if (w_done_cnt !== WCNT_W'(1)) begin
            failures++;
            $display("FAIL wrap_narrow got %0d, expected 1", w_done_cnt);
        end
        checks++;
        if (done_cnt !== CNT_W'(17)) begin
            failures++;
            $display("FAIL wrap_wide got %0d, expected 17", done_cnt);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL wrap_drain got %0d pending, expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_stall();
        test_reset_mid();
        test_clr();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
